// File: rtl/mem_stage_ctrl_if.sv
// Bundle of the EX->MEM, MEM<->data-memory and MEM->WB signals of the memory stage.
// slave: the stage controller. master: the surrounding pipeline/memory environment.
interface mem_stage_ctrl_if #(
   parameter int DATA_W    = 16,
   parameter int ADDR_W    = 16,
   parameter int PAYLOAD_W = 64,
   parameter int CNT_W     = 8
);
   // EX side
   logic                  in_valid;
   logic                  in_ready;
   logic [1:0]            in_op;
   logic                  in_byte;
   logic                  in_sext;
   logic [DATA_W-1:0]     in_alu;
   logic [DATA_W-1:0]     in_wdata;
   logic [PAYLOAD_W-1:0]  in_payload;
   // data-memory port
   logic                  mem_read;
   logic                  mem_write;
   logic [ADDR_W-1:0]     mem_addr;
   logic [DATA_W-1:0]     mem_wdata;
   logic [DATA_W/8-1:0]   mem_byte_enable;
   logic [DATA_W-1:0]     mem_rdata;
   logic                  mem_resp;
   // WB side and status
   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_W-1:0]     out_result;
   logic [DATA_W-1:0]     out_alu;
   logic [PAYLOAD_W-1:0]  out_payload;
   logic                  stall;
   logic [CNT_W-1:0]      last_latency;

   modport slave (
      input  in_valid, in_op, in_byte, in_sext, in_alu, in_wdata, in_payload,
      input  mem_rdata, mem_resp, out_ready,
      output in_ready, mem_read, mem_write, mem_addr, mem_wdata, mem_byte_enable,
      output out_valid, out_result, out_alu, out_payload, stall, last_latency
   );

   modport master (
      output in_valid, in_op, in_byte, in_sext, in_alu, in_wdata, in_payload,
      output mem_rdata, mem_resp, out_ready,
      input  in_ready, mem_read, mem_write, mem_addr, mem_wdata, mem_byte_enable,
      input  out_valid, out_result, out_alu, out_payload, stall, last_latency
   );
endinterface

// File: rtl/mem_stage_ctrl.sv
// LC-3b memory-stage controller: accepts one instruction from EX, runs the
// data-memory read/write handshake until mem_resp, and hands a registered
// result plus payload to WB over valid/ready. Supports byte loads/stores.
module mem_stage_ctrl #(
   parameter int DATA_W    = 16,
   parameter int ADDR_W    = 16,
   parameter int PAYLOAD_W = 64,
   parameter int CNT_W     = 8
) (
   input  logic            clk,
   input  logic            reset,
   mem_stage_ctrl_if.slave bus
);
   localparam int NB = DATA_W / 8;
   localparam logic [1:0] OP_LOAD  = 2'b01;
   localparam logic [1:0] OP_STORE = 2'b10;

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   state_t                state_q, state_d;
   logic [1:0]            op_q, op_d;
   logic                  byte_q, byte_d;
   logic                  sext_q, sext_d;
   logic [DATA_W-1:0]     alu_q, alu_d;
   logic [PAYLOAD_W-1:0]  payload_q, payload_d;
   logic [DATA_W-1:0]     result_q, result_d;
   logic                  out_valid_q, out_valid_d;
   logic                  mem_read_q, mem_read_d;
   logic                  mem_write_q, mem_write_d;
   logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0]     mem_wdata_q, mem_wdata_d;
   logic [NB-1:0]         mem_be_q, mem_be_d;
   logic [CNT_W-1:0]      lat_q, lat_d;
   logic [CNT_W-1:0]      last_lat_q, last_lat_d;

   logic                  in_ready;
   logic                  accept;
   logic [7:0]            load_byte;
   logic [DATA_W-1:0]     load_val;

   // Accept from IDLE, or from DONE when WB drains the current result in the same edge.
   assign in_ready = (state_q == IDLE) | ((state_q == DONE) & bus.out_ready);
   assign accept   = bus.in_valid & in_ready;

   // Load result formatting: byte lane picked by address bit 0, then sign/zero extension.
   always_comb begin
      load_byte = alu_q[0] ? bus.mem_rdata[15:8] : bus.mem_rdata[7:0];
      if (byte_q)
         load_val = {{(DATA_W-8){sext_q & load_byte[7]}}, load_byte};
      else
         load_val = bus.mem_rdata;
   end

   // Next-state logic: retire/complete the current instruction, then let an accept override.
   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      byte_d      = byte_q;
      sext_d      = sext_q;
      alu_d       = alu_q;
      payload_d   = payload_q;
      result_d    = result_q;
      out_valid_d = out_valid_q;
      mem_read_d  = mem_read_q;
      mem_write_d = mem_write_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_be_d    = mem_be_q;
      lat_d       = lat_q;
      last_lat_d  = last_lat_q;

      case (state_q)
         ACCESS: begin
            if (bus.mem_resp) begin
               mem_read_d  = 1'b0;
               mem_write_d = 1'b0;
               mem_be_d    = '0;
               result_d    = (op_q == OP_LOAD) ? load_val : alu_q;
               last_lat_d  = lat_q;
               out_valid_d = 1'b1;
               state_d     = DONE;
            end else if (lat_q != '1) begin
               lat_d = lat_q + CNT_W'(1);
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: ;
      endcase

      if (accept) begin
         op_d      = bus.in_op;
         byte_d    = bus.in_byte;
         sext_d    = bus.in_sext;
         alu_d     = bus.in_alu;
         payload_d = bus.in_payload;
         if (bus.in_op == OP_LOAD || bus.in_op == OP_STORE) begin
            state_d     = ACCESS;
            out_valid_d = 1'b0;
            mem_read_d  = (bus.in_op == OP_LOAD);
            mem_write_d = (bus.in_op == OP_STORE);
            // Both word and byte accesses go out on the word-aligned address.
            mem_addr_d  = {bus.in_alu[ADDR_W-1:1], 1'b0};
            if (bus.in_byte) begin
               mem_be_d    = {{(NB-1){1'b0}}, 1'b1} << bus.in_alu[0];
               mem_wdata_d = {NB{bus.in_wdata[7:0]}};
            end else begin
               mem_be_d    = '1;
               mem_wdata_d = bus.in_wdata;
            end
            lat_d = CNT_W'(1);
         end else begin
            // op none (and the unused encoding 11) completes in one cycle
            state_d     = DONE;
            out_valid_d = 1'b1;
            result_d    = bus.in_alu;
         end
      end
   end

   // State and registered outputs; async reset drops any in-flight access at once.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         op_q        <= 2'b00;
         byte_q      <= 1'b0;
         sext_q      <= 1'b0;
         alu_q       <= '0;
         payload_q   <= '0;
         result_q    <= '0;
         out_valid_q <= 1'b0;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_be_q    <= '0;
         lat_q       <= '0;
         last_lat_q  <= '0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         byte_q      <= byte_d;
         sext_q      <= sext_d;
         alu_q       <= alu_d;
         payload_q   <= payload_d;
         result_q    <= result_d;
         out_valid_q <= out_valid_d;
         mem_read_q  <= mem_read_d;
         mem_write_q <= mem_write_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_be_q    <= mem_be_d;
         lat_q       <= lat_d;
         last_lat_q  <= last_lat_d;
      end
   end

   assign bus.in_ready        = in_ready;
   assign bus.mem_read        = mem_read_q;
   assign bus.mem_write       = mem_write_q;
   assign bus.mem_addr        = mem_addr_q;
   assign bus.mem_wdata       = mem_wdata_q;
   assign bus.mem_byte_enable = mem_be_q;
   assign bus.out_valid       = out_valid_q;
   assign bus.out_result      = result_q;
   assign bus.out_alu         = alu_q;
   assign bus.out_payload     = payload_q;
   assign bus.stall           = (state_q == ACCESS) | ((state_q == DONE) & ~bus.out_ready);
   assign bus.last_latency    = last_lat_q;
endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Bench for mem_stage_ctrl: reset checks, a table of directed transactions,
// multi-cycle handshake sequences, and random transactions against a rule model.
module tb_mem_stage_ctrl;
   localparam int DATA_W = 16, ADDR_W = 16, PAYLOAD_W = 64, CNT_W = 8;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   mem_stage_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .PAYLOAD_W(PAYLOAD_W), .CNT_W(CNT_W)) bus();

   mem_stage_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .PAYLOAD_W(PAYLOAD_W), .CNT_W(CNT_W)) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   int tests = 0;
   int fails = 0;
   logic [7:0] m_llat;

   typedef struct {
      logic [1:0]  op;
      bit          byt;
      bit          sext;
      logic [15:0] alu;
      logic [15:0] wdata;
      logic [15:0] rdata;
      int          lat;
      logic [15:0] e_res;
      logic [15:0] e_addr;
      logic [15:0] e_wd;
      logic [1:0]  e_be;
      logic [7:0]  e_llat;
   } vec_t;

   vec_t tv[11];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // reference rules
   function automatic logic [15:0] m_res(logic [1:0] op, bit byt, bit sext, logic [15:0] alu, logic [15:0] rdata);
      int b;
      if (op == 2'd1) begin
         if (!byt) return rdata;
         b = (int'(rdata) >> (8 * int'(alu[0]))) & 'hFF;
         if (sext && b >= 128) b = b + 'hFF00;
         return 16'(b);
      end
      return alu;
   endfunction

   function automatic logic [15:0] m_addr(logic [15:0] alu);
      return alu & 16'hFFFE;
   endfunction

   function automatic logic [1:0] m_be(bit byt, logic [15:0] alu);
      return byt ? 2'(1 << int'(alu[0])) : 2'b11;
   endfunction

   function automatic logic [15:0] m_wd(bit byt, logic [15:0] wdata);
      return byt ? 16'((wdata & 16'h00FF) * 16'h0101) : wdata;
   endfunction

   task automatic drive(input logic [1:0] op, input bit byt, input bit sext, input logic [15:0] alu,
                        input logic [15:0] wdata, input logic [63:0] pl);
      bus.in_valid   = 1'b1;
      bus.in_op      = op;
      bus.in_byte    = byt;
      bus.in_sext    = sext;
      bus.in_alu     = alu;
      bus.in_wdata   = wdata;
      bus.in_payload = pl;
   endtask

   // One transaction from IDLE to retirement; the memory answers after lat strobe cycles.
   task automatic do_txn(input logic [1:0] op, input bit byt, input bit sext, input logic [15:0] alu,
                         input logic [15:0] wdata, input logic [15:0] rdata, input int lat,
                         input logic [63:0] pl,
                         output logic [15:0] res, output logic [15:0] addr, output logic [15:0] wd,
                         output logic [1:0] be, output int rcyc, output int wcyc,
                         output logic [7:0] llat, output logic [63:0] opl, output logic [15:0] oalu,
                         output bit ok);
      int  t;
      bit  done;
      ok = 1; rcyc = 0; wcyc = 0; addr = '0; wd = '0; be = '0;
      bus.out_ready = 1'b1;
      drive(op, byt, sext, alu, wdata, pl);
      @(negedge clk);
      if (!bus.in_ready) ok = 0;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      if (op == 2'd1 || op == 2'd2) begin
         t = 0; done = 0;
         while (!done && t < 1000) begin
            @(negedge clk); t++;
            if (bus.mem_read || bus.mem_write) begin
               if (bus.mem_read)  rcyc++;
               if (bus.mem_write) wcyc++;
               if (rcyc + wcyc == 1) begin
                  addr = bus.mem_addr; wd = bus.mem_wdata; be = bus.mem_byte_enable;
               end else if (addr !== bus.mem_addr || wd !== bus.mem_wdata || be !== bus.mem_byte_enable) begin
                  ok = 0;
               end
               if (rcyc + wcyc == lat) begin
                  bus.mem_resp = 1'b1; bus.mem_rdata = rdata;
               end
            end
            @(posedge clk); #1;
            if (bus.mem_resp) begin
               bus.mem_resp = 1'b0; done = 1;
            end
         end
         if (!done) ok = 0;
      end
      @(negedge clk);
      if (!bus.out_valid || bus.mem_read || bus.mem_write) ok = 0;
      res = bus.out_result; llat = bus.last_latency; opl = bus.out_payload; oalu = bus.out_alu;
      @(posedge clk); #1;
   endtask

   task automatic check_txn(input string tag, input logic [1:0] op, input bit byt, input logic [15:0] alu,
                            input int lat, input logic [63:0] pl, input logic [15:0] e_res,
                            input logic [15:0] e_addr, input logic [15:0] e_wd, input logic [1:0] e_be,
                            input logic [7:0] e_llat, input logic [15:0] rdata, input bit sext,
                            input logic [15:0] wdata);
      logic [15:0] res, addr, wd, oalu;
      logic [1:0]  be;
      int          rcyc, wcyc;
      logic [7:0]  llat;
      logic [63:0] opl;
      bit          ok;
      do_txn(op, byt, sext, alu, wdata, rdata, lat, pl, res, addr, wd, be, rcyc, wcyc, llat, opl, oalu, ok);
      chk({tag, " handshake"}, 64'(ok), 64'd1);
      chk({tag, " result"}, 64'(res), 64'(e_res));
      chk({tag, " payload"}, opl, pl);
      chk({tag, " out_alu"}, 64'(oalu), 64'(alu));
      chk({tag, " last_latency"}, 64'(llat), 64'(e_llat));
      if (op == 2'd1 || op == 2'd2) begin
         chk({tag, " addr"}, 64'(addr), 64'(e_addr));
         chk({tag, " byte_enable"}, 64'(be), 64'(e_be));
         chk({tag, " read_cycles"}, 64'(rcyc), 64'((op == 2'd1) ? lat : 0));
         chk({tag, " write_cycles"}, 64'(wcyc), 64'((op == 2'd2) ? lat : 0));
         if (op == 2'd2) chk({tag, " wdata"}, 64'(wd), 64'(e_wd));
      end
   endtask

   initial begin
      tv[0]  = '{2'd1, 1'b0, 1'b0, 16'h3001, 16'h0000, 16'hBEEF,   3, 16'hBEEF, 16'h3000, 16'h0000, 2'b11, 8'd3};
      tv[1]  = '{2'd1, 1'b1, 1'b1, 16'h3001, 16'h0000, 16'h80AA,   2, 16'hFF80, 16'h3000, 16'h0000, 2'b10, 8'd2};
      tv[2]  = '{2'd1, 1'b1, 1'b0, 16'h3001, 16'h0000, 16'h80AA,   4, 16'h0080, 16'h3000, 16'h0000, 2'b10, 8'd4};
      tv[3]  = '{2'd2, 1'b1, 1'b0, 16'h2000, 16'h12C3, 16'h0000,   1, 16'h2000, 16'h2000, 16'hC3C3, 2'b01, 8'd1};
      tv[4]  = '{2'd0, 1'b0, 1'b0, 16'h1234, 16'h0000, 16'h0000,   0, 16'h1234, 16'h0000, 16'h0000, 2'b00, 8'd1};
      tv[5]  = '{2'd2, 1'b0, 1'b0, 16'h4567, 16'hABCD, 16'h0000,   5, 16'h4567, 16'h4566, 16'hABCD, 2'b11, 8'd5};
      tv[6]  = '{2'd3, 1'b0, 1'b0, 16'h5555, 16'h0000, 16'h0000,   0, 16'h5555, 16'h0000, 16'h0000, 2'b00, 8'd5};
      tv[7]  = '{2'd1, 1'b1, 1'b1, 16'h1002, 16'h0000, 16'h12F0,   1, 16'hFFF0, 16'h1002, 16'h0000, 2'b01, 8'd1};
      tv[8]  = '{2'd2, 1'b1, 1'b0, 16'h2001, 16'h00A5, 16'h0000,   2, 16'h2001, 16'h2000, 16'hA5A5, 2'b10, 8'd2};
      tv[9]  = '{2'd1, 1'b0, 1'b0, 16'h0010, 16'h0000, 16'h7777, 300, 16'h7777, 16'h0010, 16'h0000, 2'b11, 8'd255};
      tv[10] = '{2'd1, 1'b1, 1'b0, 16'h0003, 16'h0000, 16'hFE01,   1, 16'h00FE, 16'h0002, 16'h0000, 2'b10, 8'd1};

      bus.in_valid = 1'b0; bus.in_op = 2'd0; bus.in_byte = 1'b0; bus.in_sext = 1'b0;
      bus.in_alu = '0; bus.in_wdata = '0; bus.in_payload = '0;
      bus.mem_rdata = '0; bus.mem_resp = 1'b0; bus.out_ready = 1'b1;
      m_llat = 8'd0;

      // reset values
      reset = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset out_valid", 64'(bus.out_valid), 64'd0);
      chk("reset strobes", 64'({bus.mem_read, bus.mem_write}), 64'd0);
      chk("reset mem_port", 64'({bus.mem_addr, bus.mem_wdata, bus.mem_byte_enable}), 64'd0);
      chk("reset results", 64'({bus.out_result, bus.out_alu, bus.last_latency}), 64'd0);
      chk("reset payload", bus.out_payload, 64'd0);
      @(posedge clk); #1 reset = 1'b0;
      @(negedge clk);
      chk("idle in_ready", 64'(bus.in_ready), 64'd1);
      chk("idle stall", 64'(bus.stall), 64'd0);

      // stray mem_resp in IDLE does nothing
      @(posedge clk); #1 bus.mem_resp = 1'b1; bus.mem_rdata = 16'hDEAD;
      @(posedge clk); #1 bus.mem_resp = 1'b0;
      @(negedge clk);
      chk("stray resp out_valid", 64'(bus.out_valid), 64'd0);
      chk("stray resp in_ready", 64'(bus.in_ready), 64'd1);
      chk("stray resp latency", 64'(bus.last_latency), 64'd0);

      // reset asserted mid-access
      @(posedge clk); #1 drive(2'd1, 1'b0, 1'b0, 16'h3001, 16'h0, 64'h55);
      @(posedge clk); #1 bus.in_valid = 1'b0;
      @(negedge clk);
      chk("midreset mem_read before", 64'(bus.mem_read), 64'd1);
      #2 reset = 1'b1;
      #1;
      chk("midreset mem_read", 64'(bus.mem_read), 64'd0);
      chk("midreset out_valid", 64'(bus.out_valid), 64'd0);
      @(posedge clk); #1 reset = 1'b0;
      @(negedge clk);
      chk("midreset in_ready", 64'(bus.in_ready), 64'd1);
      chk("midreset stays idle", 64'({bus.mem_read, bus.stall}), 64'd0);
      @(posedge clk); #1;

      // directed table
      for (int i = 0; i < 11; i++) begin
         check_txn($sformatf("vec%0d", i), tv[i].op, tv[i].byt, tv[i].alu, tv[i].lat,
                   64'hC0DE_0000_0000_0000 | 64'(i), tv[i].e_res, tv[i].e_addr, tv[i].e_wd,
                   tv[i].e_be, tv[i].e_llat, tv[i].rdata, tv[i].sext, tv[i].wdata);
      end
      m_llat = tv[10].e_llat;

      // back-to-back op none, one per cycle
      bus.out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         drive(2'd0, 1'b0, 1'b0, 16'h1234, 16'h0, 64'h100 + 64'(i));
         @(posedge clk); #1;
         @(negedge clk);
         chk($sformatf("b2b%0d out_valid", i), 64'(bus.out_valid), 64'd1);
         chk($sformatf("b2b%0d result", i), 64'(bus.out_result), 64'h1234);
         chk($sformatf("b2b%0d payload", i), bus.out_payload, 64'h100 + 64'(i));
         chk($sformatf("b2b%0d stall/in_ready", i), 64'({bus.stall, bus.in_ready}), 64'b01);
      end
      bus.in_valid = 1'b0;
      @(posedge clk); #1;

      // DONE held by WB back-pressure, then same-edge accept
      bus.out_ready = 1'b0;
      drive(2'd0, 1'b0, 1'b0, 16'hAAAA, 16'h0, 64'h200);
      @(posedge clk); #1;
      drive(2'd0, 1'b0, 1'b0, 16'h5555, 16'h0, 64'h201);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk($sformatf("hold%0d in_ready/stall/valid", i), 64'({bus.in_ready, bus.stall, bus.out_valid}), 64'b011);
         chk($sformatf("hold%0d result", i), 64'(bus.out_result), 64'hAAAA);
         chk($sformatf("hold%0d payload", i), bus.out_payload, 64'h200);
         @(posedge clk); #1;
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      chk("release in_ready/stall", 64'({bus.in_ready, bus.stall}), 64'b10);
      @(posedge clk); #1 bus.in_valid = 1'b0;
      @(negedge clk);
      chk("release next result", 64'(bus.out_result), 64'h5555);
      chk("release next payload", bus.out_payload, 64'h201);
      chk("release next valid", 64'(bus.out_valid), 64'd1);
      @(posedge clk); #1;

      // random transactions against the rule model
      for (int n = 0; n < 40; n++) begin
         logic [1:0]  op;
         bit          byt, sext;
         logic [15:0] alu, wdata, rdata;
         int          lat;
         logic [63:0] pl;
         op = 2'($urandom_range(0, 3)); byt = 1'($urandom); sext = 1'($urandom);
         alu = 16'($urandom); wdata = 16'($urandom); rdata = 16'($urandom);
         lat = $urandom_range(1, 6); pl = {$urandom, $urandom};
         if (op == 2'd1 || op == 2'd2) m_llat = 8'((lat > 255) ? 255 : lat);
         check_txn($sformatf("rnd%0d", n), op, byt, alu, lat, pl, m_res(op, byt, sext, alu, rdata),
                   m_addr(alu), m_wd(byt, wdata), m_be(byt, alu), m_llat, rdata, sext, wdata);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
